// File: rtl/sn76489_cpu_interface_pkg.sv
// Shared definitions for the SN76489 CPU write port.
// Contents: 3-bit register select codes as they appear in d[3:1] of a latch byte,
// the attenuation reset value, the write-cycle length and the FSM state type.
package sn76489_cpu_interface_pkg;

  localparam logic [2:0] REG_FREQ1    = 3'b000;
  localparam logic [2:0] REG_FREQ3    = 3'b001;
  localparam logic [2:0] REG_FREQ2    = 3'b010;
  localparam logic [2:0] REG_NOISE    = 3'b011;
  localparam logic [2:0] REG_ATT1     = 3'b100;
  localparam logic [2:0] REG_ATT3     = 3'b101;
  localparam logic [2:0] REG_ATT2     = 3'b110;
  localparam logic [2:0] REG_ATTNOISE = 3'b111;

  localparam logic [3:0] ATT_RESET = 4'hF;

  // Clocks from write start to commit; the counter holds 1..WRITE_CYCLES-1.
  localparam int unsigned WRITE_CYCLES = 32;
  localparam logic [4:0]  CNT_LAST     = 5'(WRITE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sn76489_cpu_interface_if.sv
// CPU bus of the SN76489 write port.
//   d     : data byte from the CPU
//   nWE   : write enable, active low
//   nCE   : chip enable, active low
//   ready : 0 while selected and the write cycle has not completed
// master = CPU side, slave = PSG side.
interface sn76489_cpu_interface_if;
  logic [7:0] d;
  logic       nWE;
  logic       nCE;
  logic       ready;

  modport master (output d, output nWE, output nCE, input ready);
  modport slave  (input d, input nWE, input nCE, output ready);
endinterface

// File: rtl/sn76489_cpu_interface.sv
// CPU-side write port of the SN76489 PSG.
// A byte is captured when nCE and nWE both go low, held for a 32-clock write
// cycle (ready low), then decoded into the tone, attenuation and noise registers.
// Ports:
//   clock, reset   : PSG clock, synchronous active-high reset
//   bus            : CPU bus (d, nWE, nCE in; ready out)
//   freq1..freq3   : 10-bit tone period registers
//   att1..att3     : 4-bit tone attenuation registers
//   attNoise       : 4-bit noise attenuation register
//   noiseControl   : 3-bit noise control register
module sn76489_cpu_interface
  import sn76489_cpu_interface_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  sn76489_cpu_interface_if.slave        bus,
  output logic [9:0]                    freq1,
  output logic [9:0]                    freq2,
  output logic [9:0]                    freq3,
  output logic [3:0]                    att1,
  output logic [3:0]                    att2,
  output logic [3:0]                    att3,
  output logic [3:0]                    attNoise,
  output logic [2:0]                    noiseControl
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;
  logic        r_ready;
  logic        w_ready_nxt;
  logic        w_capture;
  logic        w_commit;
  logic [7:0]  r_byte;
  logic [2:0]  r_latched;

  logic [9:0]  r_freq1;
  logic [9:0]  r_freq2;
  logic [9:0]  r_freq3;
  logic [3:0]  r_att1;
  logic [3:0]  r_att2;
  logic [3:0]  r_att3;
  logic [3:0]  r_att_noise;
  logic [2:0]  r_noise_ctrl;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.nCE) begin
          w_ready_nxt = 1'b1;
        end else begin
          w_ready_nxt = 1'b0;
          if (!bus.nWE) begin
            w_capture   = 1'b1;
            w_cnt_nxt   = 5'd1;
            w_state_nxt = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (bus.nCE || bus.nWE) begin
          w_ready_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_commit    = 1'b1;
          w_ready_nxt = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      ST_DONE: begin
        // No retrigger while still selected: a new write needs nCE to rise first.
        w_ready_nxt = 1'b1;
        if (bus.nCE) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_ready_nxt = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_ready      <= 1'b1;
      r_byte       <= '0;
      r_latched    <= REG_FREQ1;
      r_freq1      <= '0;
      r_freq2      <= '0;
      r_freq3      <= '0;
      r_att1       <= ATT_RESET;
      r_att2       <= ATT_RESET;
      r_att3       <= ATT_RESET;
      r_att_noise  <= ATT_RESET;
      r_noise_ctrl <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      if (w_capture) begin
        r_byte <= bus.d;
      end
      if (w_commit) begin
        if (r_byte[0]) begin
          // Latch byte: select register and load its high/only field.
          r_latched <= r_byte[3:1];
          case (r_byte[3:1])
            REG_FREQ1:    r_freq1[9:6] <= r_byte[7:4];
            REG_FREQ2:    r_freq2[9:6] <= r_byte[7:4];
            REG_FREQ3:    r_freq3[9:6] <= r_byte[7:4];
            REG_NOISE:    r_noise_ctrl <= r_byte[7:5];
            REG_ATT1:     r_att1       <= r_byte[7:4];
            REG_ATT2:     r_att2       <= r_byte[7:4];
            REG_ATT3:     r_att3       <= r_byte[7:4];
            REG_ATTNOISE: r_att_noise  <= r_byte[7:4];
          endcase
        end else begin
          // Data byte only reaches tone registers; others ignore it.
          case (r_latched)
            REG_FREQ1: r_freq1[5:0] <= r_byte[7:2];
            REG_FREQ2: r_freq2[5:0] <= r_byte[7:2];
            REG_FREQ3: r_freq3[5:0] <= r_byte[7:2];
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.ready    = r_ready;
  assign freq1        = r_freq1;
  assign freq2        = r_freq2;
  assign freq3        = r_freq3;
  assign att1         = r_att1;
  assign att2         = r_att2;
  assign att3         = r_att3;
  assign attNoise     = r_att_noise;
  assign noiseControl = r_noise_ctrl;

endmodule

// File: tb/tb_sn76489_cpu_interface.sv
// Self-checking bench for sn76489_cpu_interface: a directed vector table,
// hand-written timing/abort/DONE/reset sequences, and random writes checked
// against an arithmetic register model.
module tb_sn76489_cpu_interface;

  logic       clock;
  logic       reset;
  logic [9:0] freq1, freq2, freq3;
  logic [3:0] att1, att2, att3, attNoise;
  logic [2:0] noiseControl;

  sn76489_cpu_interface_if bus ();

  sn76489_cpu_interface dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .freq1        (freq1),
    .freq2        (freq2),
    .freq3        (freq3),
    .att1         (att1),
    .att2         (att2),
    .att3         (att3),
    .attNoise     (attNoise),
    .noiseControl (noiseControl)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: registers indexed as tones 0..2 = freq1..3, atts 0..3 = att1..3, attNoise.
  int m_freq[3];
  int m_att[4];
  int m_noise;
  int m_latched;
  // Register code -> index into m_freq (codes 0..2) or m_att (codes 4..7); code 3 = noise.
  int code_idx[8] = '{0, 2, 1, -1, 0, 2, 1, 3};

  typedef struct {
    logic [7:0] d;
    logic [9:0] f1, f2, f3;
    logic [3:0] a1, a2, a3, an;
    logic [2:0] nc;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(logic [7:0] d, int f1, int f2, int f3,
                              int a1, int a2, int a3, int an, int nc);
    vec_t v;
    v.d  = d;
    v.f1 = 10'(f1); v.f2 = 10'(f2); v.f3 = 10'(f3);
    v.a1 = 4'(a1);  v.a2 = 4'(a2);  v.a3 = 4'(a3);  v.an = 4'(an);
    v.nc = 3'(nc);
    return v;
  endfunction

  function automatic logic [48:0] pack_vec(vec_t v);
    return {v.f1, v.f2, v.f3, v.a1, v.a2, v.a3, v.an, v.nc};
  endfunction

  function automatic logic [48:0] dut_regs();
    return {freq1, freq2, freq3, att1, att2, att3, attNoise, noiseControl};
  endfunction

  function automatic logic [48:0] model_regs();
    return {10'(m_freq[0]), 10'(m_freq[1]), 10'(m_freq[2]),
            4'(m_att[0]), 4'(m_att[1]), 4'(m_att[2]), 4'(m_att[3]), 3'(m_noise)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_freq[i] = 0;
    for (int i = 0; i < 4; i++) m_att[i] = 15;
    m_noise   = 0;
    m_latched = 0;
  endtask

  task automatic model_commit(input logic [7:0] b);
    int v;
    int code;
    v = int'(b);
    if (v % 2 == 1) begin
      code      = (v / 2) % 8;
      m_latched = code;
      if (code == 3)
        m_noise = v / 32;
      else if (code < 4)
        m_freq[code_idx[code]] = (v / 16) * 64 + m_freq[code_idx[code]] % 64;
      else
        m_att[code_idx[code]] = v / 16;
    end else if (m_latched < 3) begin
      m_freq[code_idx[m_latched]] = (m_freq[code_idx[m_latched]] / 64) * 64 + v / 4;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Full 32-clock write; returns in IDLE after deselecting for one clock.
  task automatic write_byte(input logic [7:0] b);
    bus.d   = b;
    bus.nCE = 1'b0;
    bus.nWE = 1'b0;
    repeat (31) @(posedge clock);
    #1;
    chk("ready_low_edge31", 64'(bus.ready), 64'd0);
    @(posedge clock);
    #1;
    chk("ready_high_edge32", 64'(bus.ready), 64'd1);
    bus.nCE = 1'b1;
    bus.nWE = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    int         k;

    vt[0]  = mk(8'h51, 320,   0,   0, 15, 15, 15, 15, 0);
    vt[1]  = mk(8'h28, 330,   0,   0, 15, 15, 15, 15, 0);
    vt[2]  = mk(8'h25, 330, 128,   0, 15, 15, 15, 15, 0);
    vt[3]  = mk(8'hE0, 330, 184,   0, 15, 15, 15, 15, 0);
    vt[4]  = mk(8'h33, 330, 184, 192, 15, 15, 15, 15, 0);
    vt[5]  = mk(8'hE0, 330, 184, 248, 15, 15, 15, 15, 0);
    vt[6]  = mk(8'hA9, 330, 184, 248, 10, 15, 15, 15, 0);
    vt[7]  = mk(8'h5D, 330, 184, 248, 10,  5, 15, 15, 0);
    vt[8]  = mk(8'hDB, 330, 184, 248, 10,  5, 13, 15, 0);
    vt[9]  = mk(8'hEF, 330, 184, 248, 10,  5, 13, 14, 0);
    vt[10] = mk(8'hA7, 330, 184, 248, 10,  5, 13, 14, 5);
    vt[11] = mk(8'hFC, 330, 184, 248, 10,  5, 13, 14, 5);
    vt[12] = mk(8'h71, 458, 184, 248, 10,  5, 13, 14, 5);
    vt[13] = mk(8'hFE, 511, 184, 248, 10,  5, 13, 14, 5);

    reset   = 1'b1;
    bus.d   = 8'h00;
    bus.nCE = 1'b1;
    bus.nWE = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("reset_ready", 64'(bus.ready), 64'd1);
    chk("reset_regs", 64'(dut_regs()), 64'(model_regs()));

    // Directed table
    for (int i = 0; i < 14; i++) begin
      write_byte(vt[i].d);
      model_commit(vt[i].d);
      chk($sformatf("vec%0d_regs", i), 64'(dut_regs()), 64'(pack_vec(vt[i])));
    end

    // Ready timing: selected without write, then a full write cycle.
    bus.d   = 8'h8F;
    bus.nCE = 1'b0;
    bus.nWE = 1'b1;
    @(posedge clock);
    #1;
    chk("ready_selected_no_we", 64'(bus.ready), 64'd0);
    bus.nWE = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      @(posedge clock);
      #1;
      chk($sformatf("timing_ready_e%0d", e), 64'(bus.ready), 64'd0);
    end
    chk("timing_regs_before_commit", 64'(dut_regs()), 64'(model_regs()));
    @(posedge clock);
    #1;
    model_commit(8'h8F);
    chk("timing_ready_e32", 64'(bus.ready), 64'd1);
    chk("timing_regs_commit", 64'(dut_regs()), 64'(model_regs()));
    bus.nCE = 1'b1;
    bus.nWE = 1'b1;
    @(posedge clock);
    #1;
    chk("timing_idle_ready", 64'(bus.ready), 64'd1);

    // Abort after 10 clocks: no commit, ready back high on the next edge.
    bus.d   = 8'h01;
    bus.nCE = 1'b0;
    bus.nWE = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    bus.nWE = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_ready", 64'(bus.ready), 64'd1);
    chk("abort_regs", 64'(dut_regs()), 64'(model_regs()));
    bus.nCE = 1'b1;
    @(posedge clock);
    #1;

    // DONE hold: stay selected with nWE low and a different byte; no second commit.
    bus.d   = 8'h11;
    bus.nCE = 1'b0;
    bus.nWE = 1'b0;
    repeat (32) @(posedge clock);
    #1;
    model_commit(8'h11);
    chk("done_first_commit", 64'({bus.ready, dut_regs()}), 64'({1'b1, model_regs()}));
    bus.d = 8'h91;
    for (int e = 0; e < 40; e++) begin
      @(posedge clock);
      #1;
      chk($sformatf("done_hold_%0d", e), 64'({bus.ready, dut_regs()}), 64'({1'b1, model_regs()}));
    end
    bus.nCE = 1'b1;
    bus.nWE = 1'b1;
    @(posedge clock);
    #1;

    // Reset in the middle of a write discards it and restores reset values.
    bus.d   = 8'h3F;
    bus.nCE = 1'b0;
    bus.nWE = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    bus.nCE = 1'b1;
    bus.nWE = 1'b1;
    model_reset();
    chk("midreset_ready", 64'(bus.ready), 64'd1);
    chk("midreset_regs", 64'(dut_regs()), 64'(model_regs()));
    @(posedge clock);
    #1;

    // Random writes and aborts against the model.
    for (int it = 0; it < 250; it++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        k       = $urandom_range(1, 31);
        bus.d   = b;
        bus.nCE = 1'b0;
        bus.nWE = 1'b0;
        repeat (k) @(posedge clock);
        #1;
        if ($urandom_range(0, 1) == 0) bus.nWE = 1'b1;
        else                           bus.nCE = 1'b1;
        @(posedge clock);
        #1;
        chk($sformatf("rand%0d_abort", it), 64'({bus.ready, dut_regs()}), 64'({1'b1, model_regs()}));
        bus.nCE = 1'b1;
        bus.nWE = 1'b1;
        @(posedge clock);
        #1;
      end else begin
        write_byte(b);
        model_commit(b);
        chk($sformatf("rand%0d_d%02h", it, b), 64'(dut_regs()), 64'(model_regs()));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
